// File: rtl/tug_field.sv
// ---------------------------------------------------------------------------
// tug_field -- playfield stage of the tug-of-war game.
//
// Turns the two player button levels into single-step press events and walks
// one lit LED along a NUM_LEDS-wide strip. The victory detector downstream
// watches led9/led1 together with the button levels and raises freeze while
// it shows a winner.
//
// Optional feature: define DEBOUNCE_EN to put a DEBOUNCE_CYCLES-sample
// filter in front of each press detector. Without it, raw L/R feed the
// press detectors directly.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   L, R    in   left/right button levels (already synchronised), active high
//   freeze  in   high while a winner is shown; blocks all movement
//   leds    out  one-hot strip, leds[0] = LED1 (right), leds[NUM_LEDS-1] = LED9
//   led9    out  leds[NUM_LEDS-1]
//   led1    out  leds[0]
//   moved   out  one-cycle pulse in the cycle after any position change
// ---------------------------------------------------------------------------
module tug_field #(
  parameter int NUM_LEDS        = 9,
  parameter int CENTER          = 5,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                L,
  input  logic                R,
  input  logic                freeze,
  output logic [NUM_LEDS-1:0] leds,
  output logic                led9,
  output logic                led1,
  output logic                moved
);

  if (NUM_LEDS < 3 || NUM_LEDS > 16 || CENTER < 1 || CENTER > NUM_LEDS ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
    $error("tug_field: parameter out of legal range");
  end

  localparam logic [NUM_LEDS-1:0] CENTER_ONEHOT = NUM_LEDS'(1) << (CENTER - 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} press_state_t;

  // Bit 1 is the left player, bit 0 the right player.
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] press;

  assign raw = {L, R};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    press_state_t state_reg;
    press_state_t state_next;
    logic         press_evt;
    // arm_reg blocks a press from a button that was already down when reset
    // was applied; it re-arms as soon as the raw level is seen low.
    logic         arm_reg;

`ifdef DEBOUNCE_EN
    logic [7:0] cnt_reg;
    logic       filt_reg;

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive samples
    // that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg  <= '0;
        filt_reg <= 1'b0;
      end else if (raw[gi] == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg  <= '0;
        filt_reg <= raw[gi];
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end

    assign level[gi] = filt_reg;
`else
    assign level[gi] = raw[gi];
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= IDLE;
        arm_reg   <= ~raw[gi];
      end else begin
        state_reg <= state_next;
        arm_reg   <= arm_reg | ~raw[gi];
      end
    end

    always_comb begin
      state_next = state_reg;
      press_evt  = 1'b0;
      case (state_reg)
        IDLE: begin
          if (level[gi]) begin
            state_next = HELD;
            press_evt  = arm_reg;
          end
        end
        HELD: begin
          if (!level[gi]) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    assign press[gi] = press_evt;
  end

  logic [NUM_LEDS-1:0] leds_reg;
  logic [NUM_LEDS-1:0] leds_next;
  logic                moved_reg;
  logic                move;

  // Shifting the one-hot vector keeps it one-hot; the end checks make the
  // light saturate instead of falling off either side of the strip.
  always_comb begin
    leds_next = leds_reg;
    move      = 1'b0;
    if (!freeze) begin
      if (press[1] && !press[0] && !leds_reg[NUM_LEDS-1]) begin
        leds_next = leds_reg << 1;
        move      = 1'b1;
      end else if (press[0] && !press[1] && !leds_reg[0]) begin
        leds_next = leds_reg >> 1;
        move      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_reg  <= CENTER_ONEHOT;
      moved_reg <= 1'b0;
    end else begin
      leds_reg  <= leds_next;
      moved_reg <= move;
    end
  end

  assign leds  = leds_reg;
  assign led9  = leds_reg[NUM_LEDS-1];
  assign led1  = leds_reg[0];
  assign moved = moved_reg;

endmodule
